// File: rtl/pipe_pkg.sv
// Shared types for pipeline-stage latches: stage state encoding and occupancy decode.
package pipe_pkg;

    localparam int unsigned PIPE_OCC_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

    // Illegal encoding reports as empty, matching where the stage recovers to.
    function automatic logic [PIPE_OCC_W-1:0] occ_of(input pipe_state_t st);
        logic [PIPE_OCC_W-1:0] occ;
        case (st)
            ST_HALF: occ = 2'd1;
            ST_FULL: occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle between two pipeline stages (upstream and downstream sides).
interface pipe_stage_skid_if #(
    parameter int unsigned W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    // master: the environment driving the stage; slave: the stage itself
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter for stall/hazard profiling; cleared only by reset.
module pipe_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage latch with valid/ready handshake and a 2-entry skid buffer; all outputs from flops.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned W             = 32,
    parameter bit          ZERO_ON_FLUSH = 1'b1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    pipe_stage_skid_if.slave      bus,
    output logic [PIPE_OCC_W-1:0] occupancy,
    output logic [CNT_W-1:0]      stall_cnt
);

    pipe_state_t  state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_ready_w;
    logic         out_valid_w;
    logic         acc;
    logic         dlv;

    // ST_FULL and the illegal code both have bit 1 set, so neither accepts
    assign in_ready_w  = ~state_q[1];
    assign out_valid_w = state_q[1] ^ state_q[0];
    assign acc         = bus.in_valid & in_ready_w;
    assign dlv         = out_valid_w & bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (clr) begin
            state_d = ST_EMPTY;
            if (ZERO_ON_FLUSH) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        main_d  = bus.in_data;
                        state_d = ST_HALF;
                    end
                end
                ST_HALF: begin
                    if (acc && dlv) begin
                        main_d = bus.in_data;
                    end else if (acc) begin
                        skid_d  = bus.in_data;
                        state_d = ST_FULL;
                    end else if (dlv) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (dlv) begin
                        main_d  = skid_q;
                        state_d = ST_HALF;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = main_q;
    assign occupancy     = occ_of(state_q);

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_valid_w & ~bus.out_ready),
        .cnt   (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench: one stage with flush zeroing and a 3-bit stall counter, one without.
module tb_pipe_stage_skid;

    logic        clk;
    logic        rst_n;
    logic        clr0;
    logic        clr1;
    logic [1:0]  occ0;
    logic [1:0]  occ1;
    logic [2:0]  stall0;
    logic [15:0] stall1;

    int n_checks;
    int n_fail;

    pipe_stage_skid_if #(.W(32)) bus0 ();
    pipe_stage_skid_if #(.W(32)) bus1 ();

    pipe_stage_skid #(
        .W             (32),
        .ZERO_ON_FLUSH (1'b1),
        .CNT_W         (3)
    ) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr0),
        .bus       (bus0),
        .occupancy (occ0),
        .stall_cnt (stall0)
    );

    pipe_stage_skid #(
        .W             (32),
        .ZERO_ON_FLUSH (1'b0),
        .CNT_W         (16)
    ) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr1),
        .bus       (bus1),
        .occupancy (occ1),
        .stall_cnt (stall1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench still running, required finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        clr0           = 1'b0;
        clr1           = 1'b0;
        bus0.in_valid  = 1'b0;
        bus0.in_data   = '0;
        bus0.out_ready = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_data   = '0;
        bus1.out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        check_eq("rst_out_valid", 64'(bus0.out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(bus0.in_ready), 64'd1);
        check_eq("rst_occ", 64'(occ0), 64'd0);
        check_eq("rst_stall", 64'(stall0), 64'd0);

        // Streaming: one payload per cycle, never more than one held
        bus0.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus0.in_valid = 1'b1;
            bus0.in_data  = 32'(i);
            tick();
            check_eq($sformatf("stream_data_%0d", i), 64'(bus0.out_data), 64'(i));
            check_eq($sformatf("stream_valid_%0d", i), 64'(bus0.out_valid), 64'd1);
            check_eq($sformatf("stream_occ_%0d", i), 64'(occ0), 64'd1);
        end
        bus0.in_valid = 1'b0;
        tick();
        check_eq("stream_drain_valid", 64'(bus0.out_valid), 64'd0);
        check_eq("stream_drain_occ", 64'(occ0), 64'd0);
        check_eq("stream_stall", 64'(stall0), 64'd0);

        // Back-pressure into the skid register
        bus0.out_ready = 1'b0;
        bus0.in_valid  = 1'b1;
        bus0.in_data   = 32'hA;
        tick();
        check_eq("bp_half_data", 64'(bus0.out_data), 64'hA);
        check_eq("bp_half_occ", 64'(occ0), 64'd1);
        bus0.in_data = 32'hB;
        tick();
        check_eq("bp_full_occ", 64'(occ0), 64'd2);
        check_eq("bp_full_in_ready", 64'(bus0.in_ready), 64'd0);
        check_eq("bp_full_data", 64'(bus0.out_data), 64'hA);
        check_eq("bp_full_stall", 64'(stall0), 64'd1);
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        tick();
        check_eq("bp_dlv1_data", 64'(bus0.out_data), 64'hB);
        check_eq("bp_dlv1_in_ready", 64'(bus0.in_ready), 64'd1);
        check_eq("bp_dlv1_occ", 64'(occ0), 64'd1);
        tick();
        check_eq("bp_dlv2_valid", 64'(bus0.out_valid), 64'd0);
        check_eq("bp_dlv2_stall", 64'(stall0), 64'd1);

        // Flush from FULL with a concurrent accept
        bus0.out_ready = 1'b0;
        bus0.in_valid  = 1'b1;
        bus0.in_data   = 32'hC;
        tick();
        bus0.in_data = 32'hD;
        tick();
        check_eq("fl_full_occ", 64'(occ0), 64'd2);
        check_eq("fl_full_data", 64'(bus0.out_data), 64'hC);
        clr0         = 1'b1;
        bus0.in_data = 32'hE;
        tick();
        check_eq("fl_occ", 64'(occ0), 64'd0);
        check_eq("fl_valid", 64'(bus0.out_valid), 64'd0);
        check_eq("fl_data", 64'(bus0.out_data), 64'd0);
        check_eq("fl_stall", 64'(stall0), 64'd3);
        clr0          = 1'b0;
        bus0.in_valid = 1'b0;
        tick();
        check_eq("fl_after_valid", 64'(bus0.out_valid), 64'd0);
        check_eq("fl_after_data", 64'(bus0.out_data), 64'd0);

        // Asynchronous reset mid-cycle while FULL
        bus0.in_valid = 1'b1;
        bus0.in_data  = 32'h11;
        tick();
        bus0.in_data = 32'h22;
        tick();
        bus0.in_valid = 1'b0;
        check_eq("ar_pre_occ", 64'(occ0), 64'd2);
        check_eq("ar_pre_stall", 64'(stall0), 64'd4);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("ar_valid", 64'(bus0.out_valid), 64'd0);
        check_eq("ar_in_ready", 64'(bus0.in_ready), 64'd1);
        check_eq("ar_occ", 64'(occ0), 64'd0);
        check_eq("ar_data", 64'(bus0.out_data), 64'd0);
        check_eq("ar_stall", 64'(stall0), 64'd0);
        tick();
        rst_n = 1'b1;

        // Stall counter saturates at 7 and survives a flush
        bus0.in_valid = 1'b1;
        bus0.in_data  = 32'h33;
        tick();
        bus0.in_valid = 1'b0;
        check_eq("sat_start", 64'(stall0), 64'd0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            check_eq($sformatf("sat_cnt_%0d", i), 64'(stall0), (i > 7) ? 64'd7 : 64'(i));
        end
        check_eq("sat_hold_data", 64'(bus0.out_data), 64'h33);
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        check_eq("sat_clr_stall", 64'(stall0), 64'd7);
        check_eq("sat_clr_occ", 64'(occ0), 64'd0);
        tick();
        check_eq("sat_idle_stall", 64'(stall0), 64'd7);
        rst_n = 1'b0;
        #1;
        check_eq("sat_rst_stall", 64'(stall0), 64'd0);
        tick();
        rst_n = 1'b1;

        // Flush without zeroing keeps the payload register
        bus1.in_valid  = 1'b1;
        bus1.in_data   = 32'h55;
        bus1.out_ready = 1'b0;
        tick();
        bus1.in_valid = 1'b0;
        check_eq("nz_half_valid", 64'(bus1.out_valid), 64'd1);
        check_eq("nz_half_data", 64'(bus1.out_data), 64'h55);
        clr1 = 1'b1;
        tick();
        clr1 = 1'b0;
        check_eq("nz_fl_valid", 64'(bus1.out_valid), 64'd0);
        check_eq("nz_fl_occ", 64'(occ1), 64'd0);
        check_eq("nz_fl_data", 64'(bus1.out_data), 64'h55);
        bus1.in_valid  = 1'b1;
        bus1.in_data   = 32'h66;
        bus1.out_ready = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        check_eq("nz_next_data", 64'(bus1.out_data), 64'h66);
        check_eq("nz_next_valid", 64'(bus1.out_valid), 64'd1);
        tick();
        check_eq("nz_empty_valid", 64'(bus1.out_valid), 64'd0);
        check_eq("nz_empty_data", 64'(bus1.out_data), 64'h66);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field inter-stage latch used between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one opaque W-bit payload, into which the stage packs control bits, ALU results and register indices.
- Replaces the single enable with a valid/ready handshake and a 2-entry skid buffer, so back-pressure does not need a combinational ready path.
- Adds a synchronous flush and a saturating stall counter for performance debug.

Parameters:
W, 32, payload width in bits (>=1)
ZERO_ON_FLUSH, 1, 1 = flush and reset clear payload registers to 0; 0 = flush clears valid only
CNT_W, 16, stall counter width in bits (>=1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous flush (bubble insert); priority over all handshake activity
in_valid  in  1  upstream payload valid
in_ready  out  1  stage can accept; driven directly from a flop
in_data  in  W  upstream payload
out_valid  out  1  downstream payload valid
out_ready  in  1  downstream accepts
out_data  out  W  payload to downstream; driven from a flop
occupancy  out  2  entries held: 0, 1 or 2
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Handshake events:
  - acc = in_valid & in_ready.
  - dlv = out_valid & out_ready.
  - Both are sampled at the rising edge of clk.
- Storage and states:
  - Storage: main register (drives out_data) and skid register.
  - ST_EMPTY: occupancy 0, out_valid 0, in_ready 1.
  - ST_HALF: occupancy 1, out_valid 1, in_ready 1.
  - ST_FULL: occupancy 2, out_valid 1, in_ready 0.
- Transitions (when clr=0):
  - EMPTY, acc: main<=in_data, go to HALF.
  - EMPTY, no acc: stay in EMPTY.
  - HALF, acc & dlv: main<=in_data, stay in HALF.
  - HALF, acc & !dlv: skid<=in_data, go to FULL.
  - HALF, !acc & dlv: go to EMPTY; main keeps its value.
  - HALF, neither: hold.
  - FULL, dlv: main<=skid, go to HALF. acc is impossible because in_ready=0.
  - FULL, no dlv: hold.
- Latency and throughput:
  - Accept to out_valid: 1 cycle.
  - Sustained throughput: 1 payload per cycle with out_ready held high.
  - Ordering: strict FIFO; no payload is dropped or duplicated.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid must not change.
- in_ready and out_valid are decoded from state flops only; there is no combinational path from any input to any output.
- clr=1:
  - Next state is EMPTY. Both entries are discarded, including a payload accepted in the same cycle.
  - If ZERO_ON_FLUSH=1, main and skid <= 0; otherwise data registers hold.
  - stall_cnt is unaffected.
- rst_n=0 (asynchronous, at any time, including mid-transfer):
  - State becomes EMPTY, so out_valid=0, in_ready=1 and occupancy=0.
  - out_data=0 and skid=0 regardless of ZERO_ON_FLUSH.
  - stall_cnt=0.
- stall_cnt:
  - Increments by 1 on each edge where out_valid=1 and out_ready=0.
  - Holds at 2^CNT_W-1 once reached; no wrap.
  - Cleared only by rst_n.
- Illegal state encoding (2'd3): treated as EMPTY on the next edge.

Decomposition:
- Shared package pipe_pkg:
  - typedef pipe_state_t, 2-bit enum: ST_EMPTY=0, ST_HALF=1, ST_FULL=2.
  - Constant PIPE_OCC_W=2.
- Sub-module pipe_sat_counter (parameter CNT_W; ports clk, rst_n, inc, cnt):
  - Instantiated once for stall_cnt.
  - Reusable by later stall/hazard profiling blocks.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst_n=0 mid-cycle with the stage in FULL.
  - Required: out_valid=0, in_ready=1, occupancy=0, out_data=0 and stall_cnt=0 immediately, without waiting for a clock edge.
- Streaming:
  - Stimulus: out_ready=1; drive in_valid=1 with in_data=0x1,0x2,...,0x8 on consecutive cycles.
  - Required: out_data shows 0x1..0x8 on consecutive cycles, starting 1 cycle after the first accept; occupancy never exceeds 1.
- Back-pressure and skid:
  - Stimulus: in HALF holding 0xA, send 0xB with out_ready=0.
  - Required: state FULL, in_ready=0, out_data holds 0xA.
  - Stimulus: then raise out_ready for 2 cycles.
  - Required: 0xA then 0xB delivered; in_ready=1 on the edge after the first dlv.
- Flush with concurrent accept:
  - Stimulus: in FULL (0xC, 0xD), assert clr=1 with in_valid=1 and in_data=0xE.
  - Required: next cycle occupancy=0, out_valid=0, out_data=0 (ZERO_ON_FLUSH=1); 0xE never appears on out_data.
- Stall counter saturation:
  - Stimulus: CNT_W=3, out_valid=1, hold out_ready=0 for 10 cycles.
  - Required: stall_cnt counts 1..7, then stays at 7.
  - Stimulus: assert clr.
  - Required: stall_cnt stays at 7; only rst_n clears it to 0.
- Flush without zeroing:
  - Stimulus: ZERO_ON_FLUSH=0, HALF holding 0x55, assert clr.
  - Required: out_valid=0 and out_data stays 0x55.
